// File: rtl/formula_result_collector.sv
// Collects formula-pipe results into a DEPTH-entry FIFO; push is visible one cycle later (no bypass).
// No backpressure upstream: words arriving while full (and not popping) are dropped and flag overflow.
// Define FORMULA_RESULT_HIGH_WATER_EN to add the max_count high-water-mark output.
module formula_result_collector #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_vld,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_vld,
    input  logic                         out_rdy,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
`ifdef FORMULA_RESULT_HIGH_WATER_EN
    output logic [$clog2(DEPTH+1)-1:0]   max_count,
`endif
    output logic                         overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("formula_result_collector: DEPTH must be a power of two and >= 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count_nxt;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

    assign out_vld  = (count != '0);
    assign out_data = mem[rd_ptr];
    assign full     = (count == CW'(DEPTH));
    assign pop      = out_vld && out_rdy;
    // A pop frees the slot this cycle, so a full buffer still takes the new word.
    assign push     = in_vld && (!full || pop);
    assign drop     = in_vld && full && !pop;

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CW'(1);
        end else if (pop && !push) begin
            count_nxt = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            count <= count_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage is deliberately unreset; out_data is only meaningful while out_vld is high.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= in_data;
        end
    end

`ifdef FORMULA_RESULT_HIGH_WATER_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            max_count <= '0;
        end else if (count_nxt > max_count) begin
            max_count <= count_nxt;
        end
    end
`endif

endmodule

// File: doc/formula_result_collector.md
FORMULA_RESULT_COLLECTOR -- requirements
Module: formula_result_collector

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, result word width.
REQ-002 The block SHALL have parameter DEPTH, default 8, buffer entries; it SHALL be a power of two and at least 2.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state SHALL change on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port in_vld, input, 1, result valid from the upstream formula pipe; there is no backpressure toward it.
REQ-006 The block SHALL have port in_data, input, WIDTH, result word from the upstream pipe.
REQ-007 The block SHALL have port out_vld, output, 1, the buffer head is valid.
REQ-008 The block SHALL have port out_rdy, input, 1, the consumer accepts the head.
REQ-009 The block SHALL have port out_data, output, WIDTH, the buffer head word.
REQ-010 The block SHALL have port count, output, $clog2(DEPTH+1), current occupancy.
REQ-011 The block SHALL have port overflow, output, 1, sticky dropped-word flag.
REQ-012 The block SHALL have port max_count, output, $clog2(DEPTH+1), high-water mark; it SHALL be present only under FORMULA_RESULT_HIGH_WATER_EN.

Function
REQ-013 Storage SHALL be a DEPTH-entry flip-flop array with read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
REQ-014 Pop SHALL occur when out_vld && out_rdy; out_rdy while out_vld=0 SHALL have no effect.
REQ-015 Push SHALL occur when in_vld && (count<DEPTH || pop); full with a simultaneous pop SHALL accept the new word.
REQ-016 Simultaneous push and pop SHALL leave count unchanged; otherwise count SHALL change by +1 on push or -1 on pop.
REQ-017 Push into an empty buffer SHALL NOT bypass: out_vld SHALL rise on the cycle after the push edge.
REQ-018 out_vld SHALL equal (count!=0); out_data SHALL be the entry at the read pointer, first-word fall-through.
REQ-019 out_data SHALL be held stable while out_vld=1 and out_rdy=0.
REQ-020 in_vld while count==DEPTH and no pop SHALL drop in_data, leave storage and pointers unchanged, and set overflow to 1 on the next edge.
REQ-021 overflow SHALL remain 1 until reset.
REQ-022 Words SHALL exit in arrival order, with no duplication and no loss except the drops defined in REQ-020.

Reset
REQ-023 On rst=1 at a clock edge, pointers, count and overflow SHALL become 0, so out_vld=0; max_count SHALL become 0 when present.
REQ-024 Reset mid-operation SHALL discard all buffered words; in_vld during the reset cycle SHALL be ignored.
REQ-025 Storage contents SHALL NOT require reset; out_data while out_vld=0 is don't-care.

Configuration
REQ-026 With FORMULA_RESULT_HIGH_WATER_EN defined, max_count SHALL update each edge to max(max_count, next count) and SHALL reset only by rst.
REQ-027 Without FORMULA_RESULT_HIGH_WATER_EN, the max_count port and its register SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-028 The bench SHALL cover: reset, then in_vld=1 with in_data=5 for one cycle, out_rdy=0 -> out_vld=1 and out_data=5 the next cycle, count=1, held indefinitely.
REQ-029 The bench SHALL cover: 8 pushes of 1..8 with out_rdy=0, then a ninth push of 9 -> count=8, overflow=1 the next cycle, and draining yields 1..8 only.
REQ-030 The bench SHALL cover: buffer full (1..8), in_vld=1 with in_data=9 and out_rdy=1 in the same cycle -> 9 is accepted, count stays 8, overflow stays 0, and the drain order is 2..9.
REQ-031 The bench SHALL cover: in_vld=1 every cycle with in_data incrementing from 0 and out_rdy=1 every cycle for 100 cycles -> count never exceeds 1, the outputs are 0..99 in order, and overflow=0.
REQ-032 The bench SHALL cover: rst asserted while count=5 and overflow=1 -> the next cycle shows count=0, out_vld=0 and overflow=0, and a subsequent push of 7 appears alone.
REQ-033 The bench SHALL cover, with FORMULA_RESULT_HIGH_WATER_EN defined: pushing 6 words, draining them all, then pushing 2 more -> max_count=6, with count=2 at the end.
